// File: rtl/otter_debug_port.sv
// otter_debug_port: MCU-side responder for the debugger command interface.
// Halts/resumes the core at instruction boundaries, performs register-file and
// memory accesses for the debugger, and pulses core reset.
// Optional build macro: OTTER_DBG_AUTO_PAUSE_EN -- when defined, register and
// memory commands issued while the core runs are wrapped in an automatic
// pause / access / resume sequence instead of being rejected.
module otter_debug_port #(
  parameter int PAUSE_TIMEOUT = 255,
  parameter int RESET_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        rst_cmd,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_rw_byte,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic        mcu_busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic [31:0] pc,
  input  logic [31:0] core_pc,
  input  logic        core_halted,
  output logic        core_halt_req,
  output logic        core_reset,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  input  logic [31:0] rf_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic        mem_re,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_dout
);

  // One shared counter serves both the pause timeout and the reset pulse.
  localparam int CNT_MAX = (PAUSE_TIMEOUT > RESET_CYCLES) ? PAUSE_TIMEOUT : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    PAUSING   = 3'd1,
    HALTED    = 3'd2,
    RF_ACC    = 3'd3,
    MEM_REQ   = 3'd4,
    MEM_WAIT  = 3'd5,
    RESETTING = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ret_halted;   // run/halt state to return to after a reset pulse
  logic             op_rd;        // current access is a read (d_rd updates at completion)

  logic [6:0] strobes;
  logic       accept;
  logic       one_strobe;
  logic       is_reg;
  logic       is_mem;
  logic       reg_addr_ok;
  logic       mem_addr_ok;

  // Memory size encoding seen by the bus: 00 = byte, 10 = word.
  function automatic logic [1:0] size_code(input logic byte_acc);
    return byte_acc ? 2'b00 : 2'b10;
  endfunction

  // Byte reads return the low lane zero-extended; word reads pass through.
  function automatic logic [31:0] read_fmt(input logic [31:0] data, input logic [1:0] size);
    return (size == 2'b00) ? {24'd0, data[7:0]} : data;
  endfunction

  assign strobes     = {pause, resume, rst_cmd, reg_rd, reg_wr, mem_rd, mem_wr};
  assign accept      = valid & ~mcu_busy;
  assign one_strobe  = $onehot(strobes);
  assign is_reg      = reg_rd | reg_wr;
  assign is_mem      = mem_rd | mem_wr;
  assign reg_addr_ok = (addr[31:5] == 27'd0);
  assign mem_addr_ok = mem_rw_byte | (addr[1:0] == 2'b00);

`ifdef OTTER_DBG_AUTO_PAUSE_EN
  logic        op_auto;
  logic        op_reg;
  logic        op_wr;
  logic        op_byte;
  logic [31:0] op_addr;
  logic [31:0] op_din;

  // Hold the accepted command so it can be launched once the core has stopped.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg  <= is_reg;
      op_wr   <= reg_wr | mem_wr;
      op_byte <= mem_rw_byte;
      op_addr <= addr;
      op_din  <= d_in;
    end
  end
`endif

  // Registered copy of the core program counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= 32'd0;
    else       pc <= core_pc;
  end

  // Command FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      cnt           <= '0;
      ret_halted    <= 1'b0;
      op_rd         <= 1'b0;
      mcu_busy      <= 1'b0;
      d_rd          <= 32'd0;
      error         <= 1'b0;
      core_halt_req <= 1'b0;
      core_reset    <= 1'b0;
      rf_addr       <= 5'd0;
      rf_wd         <= 32'd0;
      rf_we         <= 1'b0;
      mem_addr      <= 32'd0;
      mem_din       <= 32'd0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem_size      <= 2'b00;
`ifdef OTTER_DBG_AUTO_PAUSE_EN
      op_auto       <= 1'b0;
`endif
    end else begin
      case (state)
        RUN, HALTED: begin
          if (accept) begin
            error <= 1'b0;
            if (!one_strobe) begin
              error <= 1'b1;
            end else if (pause) begin
              if (state == RUN) begin
                state         <= PAUSING;
                core_halt_req <= 1'b1;
                mcu_busy      <= 1'b1;
                cnt           <= '0;
              end
            end else if (resume) begin
              if (state == HALTED) begin
                core_halt_req <= 1'b0;
                state         <= RUN;
              end
            end else if (rst_cmd) begin
              state      <= RESETTING;
              core_reset <= 1'b1;
              mcu_busy   <= 1'b1;
              cnt        <= '0;
              ret_halted <= (state == HALTED);
            end else if (is_reg && !reg_addr_ok) begin
              error <= 1'b1;
            end else if (is_mem && !mem_addr_ok) begin
              error <= 1'b1;
            end else if (state == RUN) begin
`ifdef OTTER_DBG_AUTO_PAUSE_EN
              state         <= PAUSING;
              core_halt_req <= 1'b1;
              mcu_busy      <= 1'b1;
              cnt           <= '0;
              op_auto       <= 1'b1;
              op_rd         <= reg_rd | mem_rd;
`else
              error <= 1'b1;
`endif
            end else if (is_reg) begin
              state    <= RF_ACC;
              mcu_busy <= 1'b1;
              rf_addr  <= addr[4:0];
              rf_wd    <= d_in;
              rf_we    <= reg_wr && (addr[4:0] != 5'd0);
              op_rd    <= reg_rd;
            end else begin
              state    <= MEM_REQ;
              mcu_busy <= 1'b1;
              mem_addr <= addr;
              mem_din  <= d_in;
              mem_re   <= mem_rd;
              mem_we   <= mem_wr;
              mem_size <= size_code(mem_rw_byte);
              op_rd    <= mem_rd;
            end
          end
        end

        PAUSING: begin
          if (core_halted) begin
            state    <= HALTED;
            mcu_busy <= 1'b0;
`ifdef OTTER_DBG_AUTO_PAUSE_EN
            if (op_auto) begin
              mcu_busy <= 1'b1;
              if (op_reg) begin
                state   <= RF_ACC;
                rf_addr <= op_addr[4:0];
                rf_wd   <= op_din;
                rf_we   <= op_wr && (op_addr[4:0] != 5'd0);
              end else begin
                state    <= MEM_REQ;
                mem_addr <= op_addr;
                mem_din  <= op_din;
                mem_re   <= ~op_wr;
                mem_we   <= op_wr;
                mem_size <= size_code(op_byte);
              end
            end
`endif
          end else if (cnt == CNT_W'(PAUSE_TIMEOUT - 1)) begin
            core_halt_req <= 1'b0;
            error         <= 1'b1;
            mcu_busy      <= 1'b0;
            state         <= RUN;
`ifdef OTTER_DBG_AUTO_PAUSE_EN
            op_auto       <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RF_ACC: begin
          rf_we    <= 1'b0;
          mcu_busy <= 1'b0;
          state    <= HALTED;
          if (op_rd) d_rd <= rf_rd;
`ifdef OTTER_DBG_AUTO_PAUSE_EN
          if (op_auto) begin
            op_auto       <= 1'b0;
            core_halt_req <= 1'b0;
            state         <= RUN;
          end
`endif
        end

        MEM_REQ: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          state  <= MEM_WAIT;
        end

        MEM_WAIT: begin
          mcu_busy <= 1'b0;
          state    <= HALTED;
          if (op_rd) d_rd <= read_fmt(mem_dout, mem_size);
`ifdef OTTER_DBG_AUTO_PAUSE_EN
          if (op_auto) begin
            op_auto       <= 1'b0;
            core_halt_req <= 1'b0;
            state         <= RUN;
          end
`endif
        end

        RESETTING: begin
          if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
            core_reset <= 1'b0;
            mcu_busy   <= 1'b0;
            state      <= ret_halted ? HALTED : RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state    <= RUN;
          mcu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/otter_debug_port.md
# otter_debug_port

MCU-side responder for the debug controller's command interface: it sits inside the Otter MCU between the debugger's command strobes and the core. It halts and resumes the core at instruction boundaries, performs register-file and memory reads and writes on behalf of the debugger, and pulses core reset. It reports `mcu_busy`, `d_rd`, `error` and `pc` back to the debugger.

## Interface
- `PAUSE_TIMEOUT`, 255: cycles to wait for `core_halted` before flagging an error.
- `RESET_CYCLES`, 4: length of the `core_reset` pulse.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `valid`  in  1  debugger command qualifier.
- `pause`, `resume`, `rst_cmd`, `reg_rd`, `reg_wr`, `mem_rd`, `mem_wr`  in  1 each  command strobes, qualified by `valid`.
- `mem_rw_byte`  in  1  1 = byte access, 0 = word access.
- `addr`  in  32  register index or memory address.
- `d_in`  in  32  write data.
- `mcu_busy`  out  1  command in progress.
- `d_rd`  out  32  read result.
- `error`  out  1  last command failed.
- `pc`  out  32  registered copy of `core_pc`.
- `core_pc`  in  32  core program counter.
- `core_halted`  in  1  core is stopped at an instruction boundary.
- `core_halt_req`  out  1  request the core to stop.
- `core_reset`  out  1  core reset pulse.
- `rf_addr`  out  5  register-file address.
- `rf_wd`  out  32  register-file write data.
- `rf_we`  out  1  register-file write enable.
- `rf_rd`  in  32  register-file read data, combinational.
- `mem_addr`  out  32  memory address.
- `mem_din`  out  32  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read enable.
- `mem_size`  out  2  `00` = byte, `10` = word.
- `mem_dout`  in  32  memory read data, valid one cycle after `mem_re`.

## Operation
- **Reset values:** every output is 0; state is RUN.
- **States:**
  - RUN
  - PAUSING
  - HALTED
  - RF_ACC
  - MEM_REQ
  - MEM_WAIT
  - RESETTING
- **Acceptance:** a command is accepted on an edge where `valid`=1 and `mcu_busy`=0.
  - `valid` while busy is ignored, with no error.
  - On acceptance, `error` clears, then updates at completion.
  - Zero or multiple strobes set `error`=1 and cause no action.
- **pause:**
  - In RUN: go to PAUSING and raise `core_halt_req`.
  - On `core_halted`=1, go to HALTED.
  - If `PAUSE_TIMEOUT` cycles pass without `core_halted`: drop `core_halt_req`, set `error`=1, return to RUN.
  - In HALTED: no-op, no error.
- **resume:** in HALTED, drop `core_halt_req` and go to RUN. In RUN it is a no-op.
- **rst_cmd:** hold `core_reset`=1 for `RESET_CYCLES` cycles in RESETTING, then return to the prior run/halt state. `core_halt_req` is preserved.
- **reg_rd / reg_wr:**
  - Allowed only in HALTED; otherwise `error`=1.
  - `addr[31:5]`≠0 sets `error`=1.
  - Writes to x0 complete without error and with `rf_we`=0.
  - Read result: `d_rd` = `rf_rd`.
- **mem_rd / mem_wr:**
  - Allowed only in HALTED; otherwise `error`=1.
  - Word access with `addr[1:0]`≠0 sets `error`=1 and issues no memory cycle.
  - Byte read: `d_rd` = {24'b0, `mem_dout[7:0]`}.
- **Read-only commands:** `d_rd` is updated only by reg_rd and mem_rd.
- **Reset mid-operation:** all strobes are dropped; the block returns to reset values immediately.

## Timing
Accept edge = E0.
- **Register op:**
  - After E0: `rf_addr`/`rf_wd`/`rf_we` are driven and `mcu_busy`=1.
  - At E1: `d_rd` is captured and `mcu_busy`=0.
- **Memory op:**
  - After E0: `mem_re` or `mem_we` is asserted for 1 cycle.
  - E1 moves to MEM_WAIT.
  - At E2: `d_rd` is captured and `mcu_busy`=0.
- **Pause:** `mcu_busy`=1 from E0 until the edge after `core_halted` is sampled high.
- **rst_cmd:** `mcu_busy` and `core_reset` are high for exactly `RESET_CYCLES` cycles.
- **Validation failures** (illegal state, bad address, multiple strobes): `error`=1 and `mcu_busy`=0 after E0, with no core-side activity.
- `pc` lags `core_pc` by one cycle.
- `error`, `d_rd` and `mcu_busy` change together at completion.

## Configuration
- **`OTTER_DBG_AUTO_PAUSE_EN` defined:** reg/mem commands in RUN are accepted.
  - Sequence: PAUSING, then the access, then automatic resume to RUN.
  - `mcu_busy` spans the whole sequence.
  - A pause timeout aborts the access with `error`=1.
- **Undefined:** reg/mem commands in RUN return `error`=1 with no core activity.

## Test plan
- Pause with `core_halted` rising 3 cycles later -> `core_halt_req`=1, `mcu_busy` high for 4 cycles, state HALTED, `error`=0.
- In HALTED: reg_wr `addr`=5, `d_in`=0xDEADBEEF, then reg_rd `addr`=5 -> `rf_we` pulse of 1 cycle, `d_rd`=0xDEADBEEF. A reg_wr to x0 -> `rf_we` stays 0.
- In HALTED: mem_rd word at 0x1002 -> `error`=1, `mem_re` never asserted. Byte mem_rd at 0x1002 with `mem_dout`=0x11223344 -> `d_rd`=0x00000044, busy for 2 cycles.
- Pause with `core_halted` held 0 -> `error`=1 after 255 cycles, `core_halt_req`=0, state RUN.
- `valid` with `reg_rd`+`mem_rd` both set -> `error`=1, no access. `valid` while busy -> ignored.
- Assert `reset` during MEM_WAIT -> all outputs 0 immediately. With `OTTER_DBG_AUTO_PAUSE_EN`, reg_rd in RUN -> pause, read, resume, `error`=0.
